// File: rtl/pipe_pkg.sv
// pipe_pkg: shared helpers for the valid/ready pipeline slice.
//   count_w    - width of an occupancy counter able to hold 0..stages
//   stages_ok  - legality check for the pipeline depth parameter
package pipe_pkg;

    function automatic int count_w(input int stages);
        return $clog2(stages + 1);
    endfunction

    function automatic bit stages_ok(input int stages);
        return stages >= 1;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one pipeline slot (valid bit + payload register).
//   clk   - clock, all updates on posedge
//   rst   - synchronous active-high reset, clears valid and data
//   clear - synchronous discard of the valid bit (flush)
//   en    - load enable: capture v_in/d_in this edge
//   v_in  - incoming valid bit
//   d_in  - incoming payload
//   v     - registered valid bit
//   d     - registered payload
module pipe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
            d <= '0;
        end else begin
            if (en) begin
                d <= d_in;
            end
            if (clear) begin
                v <= 1'b0;
            end else if (en) begin
                v <= v_in;
            end
        end
    end

endmodule

// File: rtl/valid_pipe.sv
// valid_pipe: STAGES-deep valid/ready pipeline with bubble collapse,
// synchronous flush and a registered occupancy count.
//   clk        - clock
//   rst        - synchronous active-high reset (overrides flush/transfers)
//   flush      - synchronous discard of all pipeline contents
//   up_valid   - upstream offers up_data
//   up_ready   - pipe accepts up_data this cycle
//   up_data    - upstream payload
//   down_valid - last stage holds a valid item
//   down_ready - downstream accepts down_data
//   down_data  - payload of the last stage
//   count      - number of valid stages (registered)
module valid_pipe
    import pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          up_valid,
    output logic                          up_ready,
    input  logic [WIDTH-1:0]              up_data,
    output logic                          down_valid,
    input  logic                          down_ready,
    output logic [WIDTH-1:0]              down_data,
    output logic [count_w(STAGES)-1:0]    count
);

    localparam int CW = count_w(STAGES);
    localparam int unsigned NS = STAGES;

    if (!stages_ok(STAGES)) begin : g_bad_stages
        $error("valid_pipe: STAGES must be at least 1");
    end

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] v_nxt;
    logic [WIDTH-1:0]  d    [STAGES];
    logic [WIDTH-1:0]  d_in [STAGES];
    logic [CW-1:0]     cnt_nxt;
    logic              tail_full;

    // rdy[i] = rdy[i+1] | ~v[i] unrolled: a stage can advance unless it and
    // every stage after it are valid while downstream stalls. Closed form
    // keeps the chain free of self-referencing vector bits.
    always_comb begin
        rdy       = '0;
        tail_full = 1'b1;
        for (int unsigned i = 0; i < NS; i++) begin
            tail_full = 1'b1;
            for (int unsigned j = i; j < NS; j++) begin
                tail_full = tail_full & v[j];
            end
            rdy[i] = down_ready | ~tail_full;
        end
    end

    assign up_ready = rdy[0] & ~flush & ~rst;

    always_comb begin
        v_in    = '0;
        v_in[0] = up_valid & up_ready;
        d_in[0] = up_data;
        for (int unsigned i = 1; i < NS; i++) begin
            v_in[i] = v[i-1];
            d_in[i] = d[i-1];
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .clear (flush),
            .en    (rdy[i]),
            .v_in  (v_in[i]),
            .d_in  (d_in[i]),
            .v     (v[i]),
            .d     (d[i])
        );
    end

    // Count tracks the valid bits the stages will hold after this edge,
    // so it is registered in lock-step with them.
    always_comb begin
        v_nxt   = '0;
        cnt_nxt = '0;
        for (int unsigned i = 0; i < NS; i++) begin
            v_nxt[i] = flush ? 1'b0 : (rdy[i] ? v_in[i] : v[i]);
            cnt_nxt  = cnt_nxt + CW'(v_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= cnt_nxt;
        end
    end

    assign down_valid = v[STAGES-1];
    assign down_data  = d[STAGES-1];

endmodule

// File: doc/valid_pipe.md
VALID_PIPE -- requirements
Module: valid_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload width in bits, legal range 1 or more.
REQ-002 SHALL have parameter STAGES, default 4: pipeline depth, legal range 1 or more; elaboration SHALL fail for STAGES < 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1 bit: synchronous discard of all pipeline contents.
REQ-006 SHALL have port up_valid, input, 1 bit: upstream offers up_data.
REQ-007 SHALL have port up_ready, output, 1 bit: pipe accepts up_data this cycle.
REQ-008 SHALL have port up_data, input, WIDTH bits: upstream payload.
REQ-009 SHALL have port down_valid, output, 1 bit: last stage holds a valid item.
REQ-010 SHALL have port down_ready, input, 1 bit: downstream accepts down_data.
REQ-011 SHALL have port down_data, output, WIDTH bits: payload of the last stage.
REQ-012 SHALL have port count, output, $clog2(STAGES+1) bits: number of valid stages.

Function
REQ-013 SHALL hold, per stage i (0..STAGES-1), one valid bit v[i] and one WIDTH-bit data register d[i]; stage STAGES-1 drives down_valid/down_data directly from registers.
REQ-014 SHALL compute advance readiness combinationally: rdy[STAGES-1] = down_ready | ~v[STAGES-1]; rdy[i] = rdy[i+1] | ~v[i]; up_ready = rdy[0] & ~flush.
REQ-015 SHALL move stage i-1 into stage i (d and v) when rdy[i] is 1; stage 0 loads up_data, with v[0] <= up_valid & up_ready, when rdy[0] is 1.
REQ-016 SHALL hold d[i] and v[i] unchanged when rdy[i] is 0 (stall); data SHALL never be duplicated or lost while flush is 0.
REQ-017 SHALL collapse bubbles: an invalid stage SHALL accept from its predecessor even when downstream is stalled.
REQ-018 SHALL give latency exactly STAGES cycles from an accepted up transfer to down_valid when no stall occurs, and sustain one transfer per cycle at full throughput.
REQ-019 SHALL, with flush high, clear every v[i] on the next edge, ignore up_valid, and drive up_ready 0; down_valid of the current cycle is still honoured if down_ready is 1.
REQ-020 SHALL make count equal the number of set v[i] bits, updated registered alongside v (not combinational from v); count SHALL reach STAGES only when all stages are valid.
REQ-021 SHALL, when the pipe is full and down_ready is 1, accept a new up item in the same cycle (simultaneous push/pop), keeping count at STAGES.
REQ-022 SHALL keep down_data stable while down_valid is 1 and down_ready is 0.

Reset
REQ-023 SHALL, on rst high at a clock edge, clear all v[i], all d[i] to 0, and count to 0; rst SHALL override flush and any transfer.
REQ-024 SHALL drive up_ready 0 in the cycle rst is high; items in flight when rst is asserted mid-operation SHALL be lost.

Structure
REQ-025 SHALL place a count-width function (clog2 of STAGES+1) and a STAGES ≥ 1 check helper in shared package pipe_pkg.
REQ-026 SHALL instantiate one sub-module pipe_stage per stage (valid+data register, load enable, sync reset, clear) via generate loop.

Verification (WIDTH=8, STAGES=4)
REQ-027 SHALL cover: reset, then 0x11,0x22,0x33 sent back-to-back with down_ready=1 -> down_valid first at cycle 4 after the first accept, then 0x11,0x22,0x33 on consecutive cycles, and count peaks at 3.
REQ-028 SHALL cover: down_ready=0, push 6 items -> 4 accepted, up_ready=0 thereafter, count=4, down_data=first item held stable.
REQ-029 SHALL cover: full pipe, down_ready=1 and up_valid=1 for 10 cycles -> one transfer in and one out each cycle, count stays 4, order preserved.
REQ-030 SHALL cover: a single item at stage 1 with down_ready=0 -> the item reaches stage 3 after 2 cycles (bubble collapse), count=1.
REQ-031 SHALL cover: flush asserted with 3 items in flight and up_valid=1 -> next cycle count=0 and down_valid=0, and the flush-cycle up item is not accepted.
REQ-032 SHALL cover: rst asserted together with flush and a transfer in a full pipe -> next cycle count=0, down_data=0x00.
